// File: rtl/aes_cbc_sequencer_if.sv
// Bundle of every signal between the CBC sequencer, its stream producer/consumer and the
// AES core. 128-bit fields are declared descending: bit 127 here is the block MSB.
// coreResult[135:8] carries the block result and coreResult[7:0] is a tag the sequencer drops.
interface aes_cbc_sequencer_if;
    // IV / configuration load
    logic         ivLoad;
    logic [127:0] ivIn;
    logic         cfgEncOrDec;
    logic [2:0]   cfgKeySize;
    // input block stream
    logic         inValid;
    logic         inReady;
    logic [127:0] inBlock;
    // output block stream
    logic         outValid;
    logic         outReady;
    logic [127:0] outBlock;
    // AES core side
    logic         coreReset;
    logic         coreEncOrDec;
    logic [2:0]   coreKeySize;
    logic [127:0] coreMessage;
    logic         coreDone;
    logic [135:0] coreResult;
    // status
    logic         busy;
    logic         timeoutErr;

    // Sequencer side.
    modport slave (
        input  ivLoad, ivIn, cfgEncOrDec, cfgKeySize,
        input  inValid, inBlock,
        output inReady,
        output outValid, outBlock,
        input  outReady,
        output coreReset, coreEncOrDec, coreKeySize, coreMessage,
        input  coreDone, coreResult,
        output busy, timeoutErr
    );

    // Environment side: block producer/consumer plus the core.
    modport master (
        output ivLoad, ivIn, cfgEncOrDec, cfgKeySize,
        output inValid, inBlock,
        input  inReady,
        input  outValid, outBlock,
        output outReady,
        input  coreReset, coreEncOrDec, coreKeySize, coreMessage,
        output coreDone, coreResult,
        input  busy, timeoutErr
    );
endinterface

// File: rtl/aes_cbc_sequencer.sv
// CBC chaining controller in front of a single-block AES core. Applies the CBC XOR before
// the core when encrypting and after it when decrypting, walks the core through its
// reset/done handshake and flags a core that never finishes.
module aes_cbc_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned CNT_W          = 11
) (
    input logic                  clock,
    input logic                  reset,
    aes_cbc_sequencer_if.slave   bus
);

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StLoad  = 3'd1,
        StRun   = 3'd2,
        StHold  = 3'd3,
        StError = 3'd4
    } state_e;

    // Watchdog value seen in the last RUN cycle before the timeout fires.
    localparam logic [CNT_W-1:0] WdogLast = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e state_q, state_d;

    logic [127:0]     chain_q, chain_d;
    logic             chain_valid_q, chain_valid_d;
    logic [127:0]     blk_q, blk_d;       // raw ciphertext kept for the next decrypt chain
    logic [127:0]     msg_q, msg_d;
    logic [127:0]     out_q, out_d;
    logic             enc_q, enc_d;
    logic [2:0]       key_q, key_d;
    logic [CNT_W-1:0] wdog_q, wdog_d;

    logic             in_ready;
    logic [127:0]     result;
    logic [7:0]       unused_tag;

    assign result     = bus.coreResult[135:8];
    assign unused_tag = bus.coreResult[7:0];

    // ivLoad takes priority over a block offered in the same cycle.
    assign in_ready = (state_q == StIdle) && chain_valid_q && !bus.ivLoad;

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and datapath next values.
    always_comb begin
        state_d       = state_q;
        chain_d       = chain_q;
        chain_valid_d = chain_valid_q;
        blk_d         = blk_q;
        msg_d         = msg_q;
        out_d         = out_q;
        enc_d         = enc_q;
        key_d         = key_q;
        wdog_d        = wdog_q;

        case (state_q)
            StIdle: begin
                if (bus.ivLoad) begin
                    chain_d       = bus.ivIn;
                    chain_valid_d = 1'b1;
                    enc_d         = bus.cfgEncOrDec;
                    key_d         = bus.cfgKeySize;
                end else if (bus.inValid && in_ready) begin
                    msg_d   = enc_q ? (bus.inBlock ^ chain_q) : bus.inBlock;
                    blk_d   = bus.inBlock;
                    state_d = StLoad;
                end
            end
            StLoad: begin
                wdog_d  = '0;
                state_d = StRun;
            end
            StRun: begin
                // coreDone outranks a timeout landing in the same cycle.
                if (bus.coreDone) begin
                    if (enc_q) begin
                        out_d   = result;
                        chain_d = result;
                    end else begin
                        out_d   = result ^ chain_q;
                        chain_d = blk_q;
                    end
                    state_d = StHold;
                end else if (wdog_q == WdogLast) begin
                    chain_valid_d = 1'b0;
                    state_d       = StError;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            StHold: begin
                if (bus.outReady) begin
                    state_d = StIdle;
                end
            end
            StError: begin
                if (bus.ivLoad) begin
                    chain_d       = bus.ivIn;
                    chain_valid_d = 1'b1;
                    enc_d         = bus.cfgEncOrDec;
                    key_d         = bus.cfgKeySize;
                    state_d       = StIdle;
                end else begin
                    chain_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            chain_q       <= '0;
            chain_valid_q <= 1'b0;
            blk_q         <= '0;
            msg_q         <= '0;
            out_q         <= '0;
            enc_q         <= 1'b0;
            key_q         <= '0;
            wdog_q        <= '0;
        end else begin
            chain_q       <= chain_d;
            chain_valid_q <= chain_valid_d;
            blk_q         <= blk_d;
            msg_q         <= msg_d;
            out_q         <= out_d;
            enc_q         <= enc_d;
            key_q         <= key_d;
            wdog_q        <= wdog_d;
        end
    end

    // Outputs decoded from the registered state so they clear with the async reset.
    assign bus.inReady      = in_ready;
    assign bus.outValid     = (state_q == StHold);
    assign bus.outBlock     = out_q;
    assign bus.coreReset    = (state_q == StRun);
    assign bus.coreEncOrDec = enc_q;
    assign bus.coreKeySize  = key_q;
    assign bus.coreMessage  = msg_q;
    assign bus.busy         = (state_q == StLoad) || (state_q == StRun) || (state_q == StHold);
    assign bus.timeoutErr   = (state_q == StError);

endmodule
